bf_weight_ctrl: RTL

//  Beam-weight configuration controller for bf_top. Accepts 5-bit signed cos/sin weight writes into a

---
 rtl/bf_pkg.sv | 27 ++
 rtl/bf_sample_div.sv | 27 ++
 rtl/bf_weight_ctrl.sv | 128 ++++++++++++
 3 files changed

// File: rtl/bf_pkg.sv
// Shared types and constants for the beam-weight controller: weight format,
// FSM states, cfg_addr field layout and boresight reset weights.
package bf_pkg;

  localparam int W_BITS      = 5;
  localparam int N_ANT       = 8;
  localparam int ANT_BITS    = 3;
  localparam int ADDR_W      = 5;
  localparam int ADDR_STREAM = 4;
  localparam int ADDR_SIN    = 3;

  typedef logic signed [W_BITS-1:0] weight_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_DONE    = 2'd2
  } bf_state_e;

  localparam weight_t COS_DEFAULT = 5'sd15;
  localparam weight_t SIN_DEFAULT = 5'sd0;

  function automatic weight_t default_weight(input logic is_sin);
    return is_sin ? SIN_DEFAULT : COS_DEFAULT;
  endfunction

endpackage

// File: rtl/bf_sample_div.sv
// Free-running fast-clock divider producing the one-cycle input-sample strobe
// (stands in for ds_clock). Tick is decoded combinationally from the count.
module bf_sample_div #(
  parameter int SAMPLE_DIV = 25
) (
  input  logic clock,
  input  logic reset_n,
  output logic sample_tick
);

  localparam logic [7:0] LAST = 8'(SAMPLE_DIV - 1);

  logic [7:0] cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end

  assign sample_tick = (cnt == LAST);

endmodule

// File: rtl/bf_weight_ctrl.sv
// Beam-weight controller: writes land in a shadow bank; a commit copies the whole
// bank into the active weights on a sample-strobe edge so no sample sees a mixed beam.
module bf_weight_ctrl
  import bf_pkg::*;
#(
  parameter int SAMPLE_DIV = 25
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  input  logic [ADDR_W-1:0]         cfg_addr,
  input  logic [W_BITS-1:0]         cfg_data,
  input  logic                      cfg_commit,
  output logic                      commit_done,
  output logic                      sample_tick,
  output logic [N_ANT*W_BITS-1:0]   w_cos_1,
  output logic [N_ANT*W_BITS-1:0]   w_sin_1,
  output logic [N_ANT*W_BITS-1:0]   w_cos_2,
  output logic [N_ANT*W_BITS-1:0]   w_sin_2,
  output bf_state_e                 dbg_state
);

  // Handshake: a write (cfg_valid) or commit (cfg_commit) is taken on the rising
  // edge that ends a cycle with cfg_ready=1; the requester holds its request
  // until then. cfg_ready never depends combinationally on the requests.

  bf_state_e state, state_nxt;
  logic      live;
  logic      wr_en;
  logic      swap_en;

  weight_t shadow [2][2][N_ANT];
  weight_t active [2][2][N_ANT];

  bf_sample_div #(
    .SAMPLE_DIV (SAMPLE_DIV)
  ) u_div (
    .clock       (clock),
    .reset_n     (reset_n),
    .sample_tick (sample_tick)
  );

  // Holds cfg_ready low until the first edge after reset release.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      live <= 1'b0;
    end else begin
      live <= 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (live && cfg_commit) state_nxt = ST_PENDING;
      ST_PENDING: if (sample_tick)        state_nxt = ST_DONE;
      ST_DONE:                            state_nxt = ST_IDLE;
      default:                            state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    cfg_ready   = 1'b0;
    commit_done = 1'b0;
    swap_en     = 1'b0;
    case (state)
      ST_IDLE:    cfg_ready   = live;
      ST_PENDING: swap_en     = sample_tick;
      ST_DONE:    commit_done = 1'b1;
      default:    cfg_ready   = 1'b0;
    endcase
  end

  assign wr_en     = cfg_valid && cfg_ready;
  assign dbg_state = state;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < 2; s++) begin
        for (int c = 0; c < 2; c++) begin
          for (int a = 0; a < N_ANT; a++) begin
            shadow[s][c][a] <= default_weight(c[0]);
          end
        end
      end
    end else if (wr_en) begin
      shadow[cfg_addr[ADDR_STREAM]][cfg_addr[ADDR_SIN]][cfg_addr[ANT_BITS-1:0]] <= cfg_data;
    end
  end

  // Whole bank moves in one edge; writes are blocked while PENDING so the copy is stable.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < 2; s++) begin
        for (int c = 0; c < 2; c++) begin
          for (int a = 0; a < N_ANT; a++) begin
            active[s][c][a] <= default_weight(c[0]);
          end
        end
      end
    end else if (swap_en) begin
      active <= shadow;
    end
  end

  always_comb begin
    w_cos_1 = '0;
    w_sin_1 = '0;
    w_cos_2 = '0;
    w_sin_2 = '0;
    for (int a = 0; a < N_ANT; a++) begin
      w_cos_1[a*W_BITS +: W_BITS] = active[0][0][a];
      w_sin_1[a*W_BITS +: W_BITS] = active[0][1][a];
      w_cos_2[a*W_BITS +: W_BITS] = active[1][0][a];
      w_sin_2[a*W_BITS +: W_BITS] = active[1][1][a];
    end
  end

endmodule
